cos_expansion_sched: RTL
========================

Name: cos_expansion_sched

Overview:
- Sequencer for the trigonometric functional-expansion stage of the FLAF front end.
- For each accepted input sample x (Q4.12), it produces the harmonic angles theta_k = k·π·x for k = 1..ORDER, one at a time.
- Each angle is driven into a single shared combinational cosine unit (17-bit angle in, signed 16-bit cosine out).
- The returned cos(k·π·x) terms are streamed out with a valid/ready handshake, so one cosine unit serves every harmonic.

Parameters:
- ORDER, 4, number of harmonics per sample (1..7).
- IDXW, 3, width of term_idx; must satisfy 2^IDXW > ORDER.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- x_in, input, 16, signed Q4.12 input sample.
- x_valid, input, 1, x_in is valid.
- x_ready, output, 1, block can accept a sample.
- theta_out, output, 17, angle to the cosine unit: two's complement Q5.12, bit16 is the sign.
- cos_in, input, 16, signed cosine returned combinationally by the cosine unit for theta_out.
- term_out, output, 16, signed cosine term.
- term_idx, output, IDXW, harmonic number k (1..ORDER) of term_out.
- term_last, output, 1, asserted with k = ORDER.
- term_valid, output, 1, term_out, term_idx and term_last are valid.
- term_ready, input, 1, downstream accepts the term.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - theta_out, term_out, base and acc = 0; term_idx = 0.
  - term_valid, term_last and busy = 0; x_ready = 1.
- States and transitions:
  - IDLE: x_ready = 1. On x_valid && x_ready, register the clamped x and go to MUL.
  - MUL: compute base = round(π·x) and set acc = base, k = 1. Go to THETA.
  - THETA: theta_out = acc, held stable so the cosine unit can settle for one full cycle. Go to CAPT.
  - CAPT: term_out <= cos_in, term_idx <= k, term_last <= (k == ORDER), term_valid <= 1. Go to HOLD.
  - HOLD: term_valid = 1 and all term_* outputs are stable while term_ready = 0.
  - On a HOLD handshake with k < ORDER: term_valid <= 0, acc <= wrap(acc + base), k <= k + 1, go to THETA.
  - On a HOLD handshake with k = ORDER: term_valid <= 0, go to IDLE.
- x_ready = 1 only in IDLE; a sample is never accepted mid-burst.
- Latency and throughput:
  - Accept at cycle 0, first term_valid at cycle 3.
  - With term_ready held high, a new term every 3 cycles.
  - A new sample can be accepted on the cycle after the last handshake.
- Clamp: x > +0x1000 becomes 0x1000; x < −0x1000 becomes 0xF000 (−1.0).
- Multiply:
  - π = 16'h3244 (Q4.12); the product is 32-bit signed Q8.24.
  - Add 0x800, then arithmetic shift right by 12, giving a 17-bit signed base with |base| ≤ 0x3244.
- Wrap (computed at 18 bits), with 2π = 0x6487:
  - s = acc + base.
  - If s > +0x6487, acc = s − 0x6487.
  - Else if s < −0x6487, acc = s + 0x6487.
  - Else acc = s.
  - Result: |theta_out| ≤ 0x6487 always, which is the range the cosine unit's single-step reduction requires.
- term_out is exactly the cos_in value sampled in CAPT; no arithmetic is applied to it.
- theta_out keeps its value outside THETA until the next THETA.
- Reset mid-burst: the burst is abandoned immediately, no partial term is emitted afterwards, and the block returns to IDLE.
- ORDER = 1: every burst is one term with term_last = 1.

Test Plan:
- Reset asserted mid-burst (after the k = 2 handshake) -> all outputs at reset values asynchronously; after release, x_ready = 1 and the next sample starts at k = 1.
- x = 0x1000, term_ready = 1 -> theta_out sequence 0x03244, 0x00001, 0x03245, 0x00002; term_idx 1..4; term_last only on k = 4; term_valid first seen 3 cycles after the accept, then every 3 cycles.
- x = 0x0800 -> theta 0x01922, 0x03244, 0x04B66, 0x00001 (wrap on k = 4); term_out equals the cosine-unit stub output for each theta.
- x = 0xF800 (−0.5) -> theta 0x1E6DE, 0x1CDBC, 0x1B49A, 0x1FFFF (negative wrap); stub cos values passed through unchanged.
- x = 0x2000 and x = 0xC000 -> clamped; theta sequences identical to x = 0x1000 and x = 0xF000 respectively.
- term_ready held low 5 cycles at k = 2 -> term_out, term_idx and term_valid stable throughout; x_valid pulsed during the stall is ignored (x_ready = 0); after release, k = 3 resumes.

Source files
------------

// File: rtl/cos_expansion_sched.sv
// cos_expansion_sched: per sample x, streams cos(k*pi*x) for k=1..ORDER via a shared cosine unit (x_* in, theta_out/cos_in to the unit, term_* out, busy)
module cos_expansion_sched #(
  parameter int ORDER = 4,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     x_in,
  input  logic            x_valid,
  output logic            x_ready,
  output logic [16:0]     theta_out,
  input  logic [15:0]     cos_in,
  output logic [15:0]     term_out,
  output logic [IDXW-1:0] term_idx,
  output logic            term_last,
  output logic            term_valid,
  input  logic            term_ready,
  output logic            busy
);
  typedef enum logic [2:0] {IDLE, MUL, THETA, CAPT, HOLD} state_t;
  localparam logic signed [15:0] ONE = 16'sh1000;
  localparam logic signed [15:0] PI = 16'sh3244;
  localparam logic signed [17:0] TWO_PI = 18'sh06487;
  state_t r_state;
  logic signed [15:0] r_x;
  logic signed [16:0] r_base, r_acc;
  logic [IDXW-1:0] r_k;
  logic signed [15:0] w_xc;
  logic signed [31:0] w_prod, w_rnd;
  logic signed [17:0] w_sum, w_wrap;
  always_comb begin
    w_xc = $signed(x_in) > ONE ? ONE : $signed(x_in) < -ONE ? -ONE : $signed(x_in);
    w_prod = r_x * PI;
    w_rnd = (w_prod + 32'sd2048) >>> 12;
    w_sum = {r_acc[16], r_acc} + {r_base[16], r_base};
    w_wrap = w_sum > TWO_PI ? w_sum - TWO_PI : w_sum < -TWO_PI ? w_sum + TWO_PI : w_sum;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_x <= '0;
      r_base <= '0;
      r_acc <= '0;
      r_k <= '0;
      theta_out <= '0;
      term_out <= '0;
      term_idx <= '0;
      term_last <= 1'b0;
      term_valid <= 1'b0;
      busy <= 1'b0;
      x_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (x_valid) begin
          r_x <= w_xc;
          r_state <= MUL;
          x_ready <= 1'b0;
          busy <= 1'b1;
        end
        MUL: begin
          r_base <= w_rnd[16:0];
          r_acc <= w_rnd[16:0];
          r_k <= IDXW'(1);
          r_state <= THETA;
        end
        THETA: begin
          theta_out <= r_acc;
          r_state <= CAPT;
        end
        CAPT: begin
          term_out <= cos_in;
          term_idx <= r_k;
          term_last <= r_k == IDXW'(ORDER);
          term_valid <= 1'b1;
          r_state <= HOLD;
        end
        HOLD: if (term_ready) begin
          term_valid <= 1'b0;
          if (r_k == IDXW'(ORDER)) begin
            r_state <= IDLE;
            x_ready <= 1'b1;
            busy <= 1'b0;
          end else begin
            r_acc <= w_wrap[16:0];
            r_k <= r_k + IDXW'(1);
            r_state <= THETA;
          end
        end
        default: begin
          r_state <= IDLE;
          x_ready <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
